// File: rtl/onehot_hold_sequencer.sv
// onehot_hold_sequencer: converts index requests (valid/ready) into a
// registered one-hot select bus x that holds each new value for at least
// MIN_HOLD cycles, so x is always one-hot and never re-changes early.
//
// Ports:
//   clk        - clock, all state updates on posedge
//   rst_n      - asynchronous active-low reset
//   req_valid  - request present
//   req_idx    - requested bit position ($clog2(W) bits)
//   req_ready  - request may be accepted this cycle (registered source)
//   x          - registered one-hot select (W bits)
//   cur_idx    - encoded index of the set bit in x
//   err        - one-cycle pulse after accepting req_idx >= W
//
// Optional feature macro: ONEHOT_HOLD_AUTO_ROTATE_EN
//   When defined, x rotates left by one after IDLE_ROTATE consecutive
//   idle cycles (ready and no request). Requests win over rotation.

module onehot_hold_sequencer #(
    parameter int W           = 4,
    parameter int MIN_HOLD    = 3,
    parameter int RESET_IDX   = 0,
    parameter int IDLE_ROTATE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    input  logic [$clog2(W)-1:0] req_idx,
    output logic                 req_ready,
    output logic [W-1:0]         x,
    output logic [$clog2(W)-1:0] cur_idx,
    output logic                 err
);

    localparam int IW = $clog2(W);
    localparam int HW = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;

    localparam logic [HW-1:0] HOLD_RLD = HW'(MIN_HOLD - 1);
    localparam logic [W-1:0]  X_RST    = W'(1) << RESET_IDX;
    localparam logic [IW-1:0] IDX_RST  = IW'(RESET_IDX);
    localparam logic [IW-1:0] IDX_MAX  = IW'(W - 1);

    // Elaboration-time parameter range checks.
    if (W < 2) begin : g_bad_w
        $error("onehot_hold_sequencer: W must be >= 2");
    end
    if (MIN_HOLD < 1) begin : g_bad_hold
        $error("onehot_hold_sequencer: MIN_HOLD must be >= 1");
    end
    if (RESET_IDX < 0 || RESET_IDX >= W) begin : g_bad_rst
        $error("onehot_hold_sequencer: RESET_IDX out of range");
    end
    if (IDLE_ROTATE < 1) begin : g_bad_idle
        $error("onehot_hold_sequencer: IDLE_ROTATE must be >= 1");
    end

    logic [W-1:0]  x_q;
    logic [W-1:0]  x_d;
    logic [IW-1:0] cur_q;
    logic [IW-1:0] cur_d;
    logic [HW-1:0] hold_q;
    logic [HW-1:0] hold_d;
    logic          err_q;
    logic          err_d;

    logic accept;
    logic idx_legal;
    logic load;
    logic rotate;

    assign req_ready = (hold_q == '0);
    assign accept    = req_valid && req_ready;

    // With W a power of two every encodable index is legal; only
    // non-power-of-two widths can see an out-of-range request.
    if (W == (1 << IW)) begin : g_pow2
        assign idx_legal = 1'b1;
    end else begin : g_npow2
        localparam logic [IW-1:0] W_IDX = IW'(W);
        assign idx_legal = (req_idx < W_IDX);
    end

    // Same-index and illegal requests complete the handshake but must
    // not disturb x or restart the hold window.
    assign load = accept && idx_legal && (req_idx != cur_q);

`ifdef ONEHOT_HOLD_AUTO_ROTATE_EN
    localparam int IRW = $clog2(IDLE_ROTATE + 1);
    localparam logic [IRW-1:0] IR_MAX = IRW'(IDLE_ROTATE);

    logic [IRW-1:0] idle_q;
    logic [IRW-1:0] idle_d;
    logic           idle_cyc;

    assign idle_cyc = req_ready && !req_valid;
    // A pending request (even one not yet ready) blocks rotation, and
    // an accepted one wins the edge outright.
    assign rotate   = idle_cyc && (idle_q == IR_MAX);

    always_comb begin
        idle_d = idle_q;
        if (rotate || !idle_cyc) begin
            idle_d = '0;
        end else if (idle_q != IR_MAX) begin
            idle_d = idle_q + IRW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign rotate = 1'b0;
`endif

    always_comb begin
        x_d    = x_q;
        cur_d  = cur_q;
        hold_d = hold_q;
        err_d  = accept && !idx_legal;
        if (load) begin
            x_d    = W'(1) << req_idx;
            cur_d  = req_idx;
            hold_d = HOLD_RLD;
        end else if (rotate) begin
            x_d    = {x_q[W-2:0], x_q[W-1]};
            cur_d  = (cur_q == IDX_MAX) ? '0 : cur_q + IW'(1);
            hold_d = HOLD_RLD;
        end else if (hold_q != '0) begin
            hold_d = hold_q - HW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q    <= X_RST;
            cur_q  <= IDX_RST;
            hold_q <= '0;
            err_q  <= 1'b0;
        end else begin
            x_q    <= x_d;
            cur_q  <= cur_d;
            hold_q <= hold_d;
            err_q  <= err_d;
        end
    end

    assign x       = x_q;
    assign cur_idx = cur_q;
    assign err     = err_q;

endmodule

// File: tb/tb_onehot_hold_sequencer.sv
// Testbench for onehot_hold_sequencer: three instances (W=4/MIN_HOLD=3,
// W=5/MIN_HOLD=3, W=4/MIN_HOLD=1/RESET_IDX=2) driven by directed steps.

module tb_onehot_hold_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       va, vb, vc;
    logic [1:0] ia, ic;
    logic [2:0] ib;
    logic       ra, rb, rc;
    logic [3:0] xa, xc;
    logic [4:0] xb;
    logic [1:0] ca, cc;
    logic [2:0] cb;
    logic       ea, eb, ec;

    onehot_hold_sequencer #(
        .W(4), .MIN_HOLD(3), .RESET_IDX(0), .IDLE_ROTATE(8)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .req_valid(va), .req_idx(ia),
        .req_ready(ra), .x(xa), .cur_idx(ca), .err(ea)
    );

    onehot_hold_sequencer #(
        .W(5), .MIN_HOLD(3), .RESET_IDX(0), .IDLE_ROTATE(8)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .req_valid(vb), .req_idx(ib),
        .req_ready(rb), .x(xb), .cur_idx(cb), .err(eb)
    );

    onehot_hold_sequencer #(
        .W(4), .MIN_HOLD(1), .RESET_IDX(2), .IDLE_ROTATE(8)
    ) u_c (
        .clk(clk), .rst_n(rst_n), .req_valid(vc), .req_idx(ic),
        .req_ready(rc), .x(xc), .cur_idx(cc), .err(ec)
    );

    typedef struct {
        string      tag;
        logic [7:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic push4(string t, int ex, int ec_, int er, int ee);
        sb.push_back('{tag: {t, ".x"},     v: 8'(ex)});
        sb.push_back('{tag: {t, ".cur"},   v: 8'(ec_)});
        sb.push_back('{tag: {t, ".ready"}, v: 8'(er)});
        sb.push_back('{tag: {t, ".err"},   v: 8'(ee)});
    endtask

    task automatic cmp(logic [7:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            n_bad++;
            $error("FAIL sb_empty observed=%0h required=<entry>", obs);
        end else begin
            e = sb.pop_front();
            n_cmp++;
            assert (obs === e.v) else begin
                n_bad++;
                $error("FAIL %s observed=%0h required=%0h",
                       e.tag, obs, e.v);
            end
        end
    endtask

    task automatic check(int d);
        case (d)
            0: begin
                cmp(8'(xa)); cmp(8'(ca)); cmp(8'(ra)); cmp(8'(ea));
            end
            1: begin
                cmp(8'(xb)); cmp(8'(cb)); cmp(8'(rb)); cmp(8'(eb));
            end
            default: begin
                cmp(8'(xc)); cmp(8'(cc)); cmp(8'(rc)); cmp(8'(ec));
            end
        endcase
    endtask

    task automatic drive(int d, logic v, int idx);
        case (d)
            0:       begin va = v; ia = 2'(idx); end
            1:       begin vb = v; ib = 3'(idx); end
            default: begin vc = v; ic = 2'(idx); end
        endcase
    endtask

    // Drive one cycle of stimulus, queue the state expected after the
    // next edge, then sample 1 time unit after that edge.
    task automatic step(int d, logic v, int idx, string t,
                        int ex, int ec_, int er, int ee);
        drive(d, v, idx);
        push4(t, ex, ec_, er, ee);
        @(posedge clk);
        #1;
        check(d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        va = 0; vb = 0; vc = 0;
        ia = 0; ib = 0; ic = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        push4("rst_a", 1, 0, 1, 0);  check(0);
        push4("rst_b", 1, 0, 1, 0);  check(1);
        push4("rst_c", 4, 2, 1, 0);  check(2);

        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, "rel_a", 1, 0, 1, 0);

        // accept 2, hold two cycles, then 3 accepted at e3
        step(0, 1, 2, "a_acc2",  4, 2, 0, 0);
        step(0, 1, 3, "a_h1",    4, 2, 0, 0);
        step(0, 1, 3, "a_h2",    4, 2, 1, 0);
        step(0, 1, 3, "a_acc3",  8, 3, 0, 0);

        // back-to-back 1,2,3,0 held continuously
        step(0, 1, 1, "a_b1h1",  8, 3, 0, 0);
        step(0, 1, 1, "a_b1h2",  8, 3, 1, 0);
        step(0, 1, 1, "a_b1",    2, 1, 0, 0);
        step(0, 1, 2, "a_b2h1",  2, 1, 0, 0);
        step(0, 1, 2, "a_b2h2",  2, 1, 1, 0);
        step(0, 1, 2, "a_b2",    4, 2, 0, 0);
        step(0, 1, 3, "a_b3h1",  4, 2, 0, 0);
        step(0, 1, 3, "a_b3h2",  4, 2, 1, 0);
        step(0, 1, 3, "a_b3",    8, 3, 0, 0);
        step(0, 1, 0, "a_b0h1",  8, 3, 0, 0);
        step(0, 1, 0, "a_b0h2",  8, 3, 1, 0);
        step(0, 1, 0, "a_b0",    1, 0, 0, 0);

        step(0, 0, 0, "a_idl1",  1, 0, 0, 0);
        step(0, 0, 0, "a_idl2",  1, 0, 1, 0);

        // same-index request: accepted, no change, no hold
        step(0, 1, 1, "a_to1",   2, 1, 0, 0);
        step(0, 0, 0, "a_to1h1", 2, 1, 0, 0);
        step(0, 0, 0, "a_to1h2", 2, 1, 1, 0);
        step(0, 1, 1, "a_same1", 2, 1, 1, 0);
        step(0, 1, 1, "a_same2", 2, 1, 1, 0);

        // async reset mid-hold
        step(0, 1, 3, "a_pre",   8, 3, 0, 0);
        va = 1'b0;
        rst_n = 1'b0;
        #1;
        push4("a_async", 1, 0, 1, 0);
        check(0);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 1, 2, "a_post",  4, 2, 0, 0);
        drive(0, 0, 0);

        // W=5: illegal indices pulse err, never touch x
        step(1, 1, 6, "b_ill6",  1, 0, 1, 1);
        step(1, 0, 0, "b_ill6n", 1, 0, 1, 0);
        step(1, 1, 4, "b_acc4", 16, 4, 0, 0);
        step(1, 1, 5, "b_h1",   16, 4, 0, 0);
        step(1, 1, 5, "b_h2",   16, 4, 1, 0);
        step(1, 1, 5, "b_ill5", 16, 4, 1, 1);
        step(1, 1, 7, "b_ill7", 16, 4, 1, 1);
        step(1, 1, 3, "b_acc3",  8, 3, 0, 0);
        drive(1, 0, 0);

        // MIN_HOLD=1: change allowed on every edge
        step(2, 1, 0, "c_acc0",  1, 0, 1, 0);
        step(2, 1, 3, "c_acc3",  8, 3, 1, 0);
        step(2, 1, 3, "c_same",  8, 3, 1, 0);
        step(2, 1, 1, "c_acc1",  2, 1, 1, 0);
        step(2, 0, 0, "c_idle",  2, 1, 1, 0);

        if (sb.size() != 0) begin
            n_bad++;
            $error("FAIL sb_leftover observed=%0d required=0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/onehot_hold_sequencer.md
Name: onehot_hold_sequencer

Overview:
- Drives a W-bit one-hot select bus `x`, sitting directly upstream of the one-hot/stability checker stage.
- Accepts index requests over a valid/ready handshake and converts each to a registered one-hot value.
- Once `x` changes, it is held for at least MIN_HOLD cycles; the downstream invariants (always one-hot, no re-change within the hold window) hold by construction.

Parameters:
- W, 4, width of `x`; legal range W >= 2.
- MIN_HOLD, 3, minimum cycles `x` holds a new value before it may change again; legal range MIN_HOLD >= 1.
- RESET_IDX, 0, bit set in `x` at reset; must be < W.
- IDLE_ROTATE, 8, idle cycles before auto-rotate (used only with the optional feature); must be >= 1.

Ports:
- clk  input  1  single clock, all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_idx  input  $clog2(W)  requested bit position.
- req_ready  output  1  request may be accepted this cycle.
- x  output  W  registered one-hot select.
- cur_idx  output  $clog2(W)  encoded index of the set bit in `x`.
- err  output  1  one-cycle pulse: accepted request had req_idx >= W.

Behaviour:
- Clock and reset: one clock (`clk`). Reset `rst_n` is asynchronous and active-low.
- Reset values: x = 1 << RESET_IDX, cur_idx = RESET_IDX, hold_cnt = 0, req_ready = 1, err = 0, idle_cnt = 0. Reset asserted mid-hold aborts the hold immediately.
- State: hold_cnt (0..MIN_HOLD-1). req_ready = (hold_cnt == 0), purely from the register, with no combinational path from req_valid.
- Accept: a request is accepted on a posedge where req_valid && req_ready.
- Accept with a new legal index (req_idx < W, req_idx != cur_idx):
  - x <= 1 << req_idx and cur_idx <= req_idx at that same edge (latency 1).
  - hold_cnt <= MIN_HOLD-1.
- Hold: while hold_cnt != 0, hold_cnt decrements each cycle and req_ready = 0. Requester must hold req_valid/req_idx stable until accepted; the block does not buffer.
- Timing example, MIN_HOLD=3: accept at edge e0; ready low after e0 and after e1; ready high after e2; next accept possible at e3.
  - A sampling checker sees !$stable(x) at e1 and next at e4 at the earliest.
  - This gives a minimum spacing of MIN_HOLD edges between changes.
- Accept with req_idx == cur_idx: handshake completes, x is unchanged, hold_cnt is not reloaded, err = 0.
- Accept with req_idx >= W (only possible when W is not a power of 2): handshake completes, x is unchanged, hold_cnt is not reloaded, err = 1 for exactly the next cycle.
- MIN_HOLD = 1: hold_cnt is permanently 0, req_ready is always 1, and x may change on every edge.
- Invariant: x is one-hot on every cycle, including reset and immediately after reset release. It never goes all-zero or multi-hot, including on illegal requests.

Optional Feature:
- Macro: ONEHOT_HOLD_AUTO_ROTATE_EN.
- With the macro defined:
  - idle_cnt counts consecutive cycles where req_ready && !req_valid, saturating at IDLE_ROTATE.
  - When idle_cnt reaches IDLE_ROTATE and req_ready, x rotates left by one (MSB wraps to bit 0), cur_idx increments mod W, hold_cnt <= MIN_HOLD-1, and idle_cnt <= 0.
  - An accepted request takes priority over rotation on the same edge and clears idle_cnt.
  - The hold rules apply to rotation exactly as to requests.
- Without the macro: idle_cnt and rotation logic are absent, and x changes only on accepted legal requests.

Test Plan:
- Reset release with W=4, RESET_IDX=0: x=4'b0001, cur_idx=0, req_ready=1, err=0. Assert rst_n low during a hold: x returns to 4'b0001 asynchronously and req_ready=1.
- req_valid=1, req_idx=2 at edge e0: x=4'b0100 after e0; req_ready=0 for 2 cycles; req_idx=3 held valid is accepted at e3; x=4'b1000 after e3.
- Back-to-back valid requests 1,2,3,0 held continuously: x changes exactly every 3 cycles, always one-hot, with no !$stable pair within 1-2 cycles.
- req_idx == cur_idx (e.g. 1 while x=4'b0010): accepted, x unchanged, req_ready stays 1 next cycle.
- W=5, req_idx=6: accepted, err=1 for one cycle, x unchanged, req_ready=1 next cycle.
- ONEHOT_HOLD_AUTO_ROTATE_EN, IDLE_ROTATE=8, no requests from x=4'b1000: x becomes 4'b0001 after 8 idle cycles, then again after a further MIN_HOLD-1+8 cycles. A request arriving on the rotate edge wins.
